// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among N_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a WAIT watchdog that pulses err on expiry.
module spi_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  input  logic                      spi_ready,
  output logic                      spi_start,
  output logic [DATA_W-1:0]         spi_tx_data,
  input  logic                      spi_done,
  input  logic [DATA_W-1:0]         spi_rx_data,
  output logic [DATA_W-1:0]         rx_data,
  output logic [N_REQ-1:0]          rx_valid,
  output logic [N_REQ-1:0]          err
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || DATA_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("spi_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] next_ptr;
  logic             found;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
`else
  assign err = '0;
`endif

  // First requester at or above ptr, wrapping past N_REQ-1 back to 0.
  always_comb begin : rr_search
    int unsigned k;
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(ptr) + i) % N_REQ;
      if (!found && req[k]) begin
        found = 1'b1;
        win   = IDX_W'(k);
      end
    end
  end

  assign next_ptr = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      spi_start   <= 1'b0;
      spi_tx_data <= '0;
      rx_data     <= '0;
      rx_valid    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err         <= '0;
      cnt         <= '0;
`endif
    end else begin
      spi_start <= 1'b0;
      rx_valid  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err       <= '0;
`endif
      case (state)
        IDLE: begin
          if (spi_ready && found) begin
            state       <= START;
            owner       <= win;
            grant       <= N_REQ'(1) << win;
            spi_tx_data <= req_data[32'(win)*DATA_W +: DATA_W];
            spi_start   <= 1'b1;
            busy        <= 1'b1;
          end
        end
        START: begin
          state <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          // spi_done takes priority over a watchdog expiry on the same edge.
          if (spi_done) begin
            state    <= RELEASE;
            rx_data  <= spi_rx_data;
            rx_valid <= grant;
            ptr      <= next_ptr;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state <= RELEASE;
            err   <= grant;
            ptr   <= next_ptr;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: expected grants/completions are queued at
// stimulus time and popped when the DUT reaches START and RELEASE.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        busy;
  logic        spi_ready;
  logic        spi_start;
  logic [7:0]  spi_tx_data;
  logic        spi_done;
  logic [7:0]  spi_rx_data;
  logic [7:0]  rx_data;
  logic [3:0]  rx_valid;
  logic [3:0]  err;

  spi_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_l(rst_l), .req(req), .req_data(req_data), .grant(grant),
    .busy(busy), .spi_ready(spi_ready), .spi_start(spi_start),
    .spi_tx_data(spi_tx_data), .spi_done(spi_done), .spi_rx_data(spi_rx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .err(err)
  );

  always #5 clk = ~clk;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int MAXD = 8;
`else
  localparam int MAXD = 12;
`endif

  typedef struct packed { logic [3:0] g; logic [7:0] d; } gexp_t;
  typedef struct packed { logic [3:0] v; logic [3:0] e; logic [7:0] d; } rexp_t;

  gexp_t      gq[$];
  rexp_t      rq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         mptr  = 0;
  int         cur_w = 0;
  logic [3:0] cur_g = '0;
  logic [7:0] last_rx = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_start"}, 32'(spi_start), 0);
    chk({tag, "_tx"}, 32'(spi_tx_data), 0);
    chk({tag, "_rxd"}, 32'(rx_data), 0);
    chk({tag, "_rxv"}, 32'(rx_valid), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic launch(input logic [3:0] r, input logic [31:0] dat);
    int w;
    req      = r;
    req_data = dat;
    w        = pick(r, mptr);
    gq.push_back({4'(1 << w), dat[w*8 +: 8]});
  endtask

  // Called one cycle after the request is sampled: DUT must be in START.
  task automatic check_start();
    gexp_t e;
    chk("start_pulse", 32'(spi_start), 1);
    chk("start_busy", 32'(busy), 1);
    if (gq.size() > 0) begin
      e = gq.pop_front();
      chk("grant", 32'(grant), 32'(e.g));
      chk("tx_data", 32'(spi_tx_data), 32'(e.d));
      cur_g = e.g;
      for (int i = 0; i < 4; i++) if (e.g[i]) cur_w = i;
    end
  endtask

  task automatic finish_release();
    rexp_t e;
    if (rq.size() > 0) begin
      e = rq.pop_front();
      chk("rx_valid", 32'(rx_valid), 32'(e.v));
      chk("err", 32'(err), 32'(e.e));
      chk("rx_data", 32'(rx_data), 32'(e.d));
      last_rx = e.d;
    end
    chk("rel_grant", 32'(grant), 32'(cur_g));
    chk("rel_busy", 32'(busy), 1);
    mptr = (cur_w + 1) % 4;
    step();
    chk("idle_grant", 32'(grant), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rxv", 32'(rx_valid), 0);
    chk("idle_err", 32'(err), 0);
    chk("idle_rxd_hold", 32'(rx_data), 32'(last_rx));
  endtask

  // Entered at START; spi_done is high in the d-th cycle after spi_start.
  task automatic complete(input int d, input logic [7:0] rxw);
    step();
    chk("wait_start_low", 32'(spi_start), 0);
    chk("wait_grant", 32'(grant), 32'(cur_g));
    repeat (d - 1) step();
    spi_done    = 1'b1;
    spi_rx_data = rxw;
    rq.push_back({cur_g, 4'b0000, rxw});
    step();
    spi_done    = 1'b0;
    spi_rx_data = 8'($urandom);
    finish_release();
  endtask

  task automatic do_reset();
    rst_l = 1'b1;
    req   = '0;
    spi_done = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst_l   = 1'b0;
    mptr    = 0;
    last_rx = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] r;
    rst_l = 1'b1; req = '0; req_data = '0; spi_ready = 1'b1;
    spi_done = 1'b0; spi_rx_data = '0;
    do_reset();

    // Fairness with all four requesting continuously.
    repeat (5) begin
      launch(4'b1111, $urandom);
      step();
      check_start();
      complete(2, 8'($urandom));
    end
    req = '0;

    // Single requester with fixed words.
    launch(4'b0001, 32'h1234_56A5);
    step();
    check_start();
    complete(4, 8'h3C);
    req = '0;

    // spi_ready low blocks arbitration.
    spi_ready = 1'b0;
    launch(4'b0010, $urandom);
    repeat (5) begin
      step();
      chk("nordy_grant", 32'(grant), 0);
      chk("nordy_start", 32'(spi_start), 0);
    end
    spi_ready = 1'b1;
    step();
    check_start();
    complete(3, 8'($urandom));
    req = '0;

    // spi_done while idle is ignored.
    step();
    spi_done = 1'b1;
    spi_rx_data = 8'hEE;
    step();
    spi_done = 1'b0;
    chk("idle_done_rxv", 32'(rx_valid), 0);
    chk("idle_done_rxd", 32'(rx_data), 32'(last_rx));
    chk("idle_done_busy", 32'(busy), 0);

    // Asynchronous reset during WAIT owned by requester 2.
    launch(4'b0100, $urandom);
    step();
    check_start();
    step();
    #3;
    rst_l = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    rst_l = 1'b0;
    mptr = 0;
    last_rx = '0;
    chk("post_reset_rxv", 32'(rx_valid), 0);
    launch(4'b0110, $urandom);
    step();
    check_start();
    complete(2, 8'($urandom));
    req = '0;

    // Owner drops req after grant; transfer still completes.
    launch(4'b1000, $urandom);
    step();
    check_start();
    req = '0;
    complete(5, 8'h5A);

    // Random traffic.
    repeat (12) begin
      r = 4'($urandom_range(1, 15));
      launch(r, $urandom);
      step();
      check_start();
      if ($urandom_range(0, 3) == 0) req = req & ~cur_g;
      complete($urandom_range(1, MAXD), 8'($urandom));
    end
    req = '0;

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog expiry after 8 WAIT cycles with no spi_done.
    launch(4'b0100, $urandom);
    step();
    check_start();
    step();
    repeat (7) step();
    chk("to_no_rel_yet", 32'(rx_valid | err), 0);
    rq.push_back({4'b0000, cur_g, last_rx});
    step();
    finish_release();
    req = '0;
    // spi_done in the 8th WAIT cycle beats the watchdog.
    launch(4'b0010, $urandom);
    step();
    check_start();
    complete(8, 8'h77);
    req = '0;
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
